// File: rtl/rf_wb_arbiter_if.sv
// Bus between the writeback sources (pipeline, MDU) and the register-file write-port arbiter.
interface rf_wb_arbiter_if #(
    parameter int unsigned addr_size = 5,
    parameter int unsigned word      = 32
);
    logic                 pipe_valid;
    logic [addr_size-1:0] pipe_addr;
    logic [word-1:0]      pipe_data;
    logic                 mdu_valid;
    logic                 mdu_ready;
    logic [addr_size-1:0] mdu_addr;
    logic [word-1:0]      mdu_data;
    logic                 stall_pipe;
    logic                 regwrite;
    logic [addr_size-1:0] write_addr;
    logic [word-1:0]      write_data;

    // Request side: pipeline and MDU.
    modport master (
        output pipe_valid, pipe_addr, pipe_data, mdu_valid, mdu_addr, mdu_data,
        input  mdu_ready, stall_pipe, regwrite, write_addr, write_data
    );

    // Arbiter side.
    modport slave (
        input  pipe_valid, pipe_addr, pipe_data, mdu_valid, mdu_addr, mdu_data,
        output mdu_ready, stall_pipe, regwrite, write_addr, write_data
    );
endinterface

// File: rtl/rf_wb_arbiter.sv
// Register-file write-port arbiter: pipeline writeback has priority, one MDU result is
// buffered and drained into idle slots, and a starved buffer forces a one-cycle pipe stall.
// Optional build macro RF_ARB_ZERO_FILTER_EN suppresses every write to register 0.
module rf_wb_arbiter #(
    parameter int unsigned addr_size  = 5,
    parameter int unsigned word       = 32,
    parameter int unsigned STARVE_MAX = 4
) (
    input logic            clk,
    input logic            rst_n,
    rf_wb_arbiter_if.slave bus
);
    typedef enum logic [1:0] {StIdle, StHeld, StForce} state_t;

    localparam logic [3:0] starve_lim = 4'(STARVE_MAX);

    state_t               state;
    logic                 buf_full;
    logic [addr_size-1:0] buf_addr;
    logic [word-1:0]      buf_data;
    logic [3:0]           wait_cnt;
    logic                 regwrite;
    logic [addr_size-1:0] write_addr;
    logic [word-1:0]      write_data;
    logic                 stall_pipe;

    logic                 pipe_we;
    logic                 mdu_keep;
    logic [3:0]           wait_next;

    // Address-0 filtering and the next wait count.
    always_comb begin
`ifdef RF_ARB_ZERO_FILTER_EN
        pipe_we  = (bus.pipe_addr != '0);
        mdu_keep = (bus.mdu_addr != '0);
`else
        pipe_we  = 1'b1;
        mdu_keep = 1'b1;
`endif
        wait_next = wait_cnt + 4'd1;
    end

    // Grant, buffer and starvation sequencing; all outputs registered.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= StIdle;
            buf_full   <= 1'b0;
            buf_addr   <= '0;
            buf_data   <= '0;
            wait_cnt   <= 4'd0;
            regwrite   <= 1'b0;
            write_addr <= '0;
            write_data <= '0;
            stall_pipe <= 1'b0;
        end else begin
            regwrite   <= 1'b0;
            stall_pipe <= 1'b0;
            case (state)
                StForce: begin
                    // Starvation slot: pipeline is stalled, the buffer owns the port.
                    regwrite   <= 1'b1;
                    write_addr <= buf_addr;
                    write_data <= buf_data;
                    buf_full   <= 1'b0;
                    wait_cnt   <= 4'd0;
                    state      <= StIdle;
                end
                default: begin
                    if (bus.pipe_valid) begin
                        regwrite   <= pipe_we;
                        write_addr <= bus.pipe_addr;
                        write_data <= bus.pipe_data;
                        if (buf_full) begin
                            if (bus.pipe_addr == buf_addr) begin
                                // Younger pipe write supersedes the buffered result.
                                buf_full <= 1'b0;
                                wait_cnt <= 4'd0;
                                state    <= StIdle;
                            end else begin
                                wait_cnt <= wait_next;
                                if (wait_next >= starve_lim) begin
                                    state      <= StForce;
                                    stall_pipe <= 1'b1;
                                end else begin
                                    state <= StHeld;
                                end
                            end
                        end
                    end else if (buf_full) begin
                        regwrite   <= 1'b1;
                        write_addr <= buf_addr;
                        write_data <= buf_data;
                        buf_full   <= 1'b0;
                        wait_cnt   <= 4'd0;
                        state      <= StIdle;
                    end
                    // Capture only happens with an empty buffer, so never alongside a drain.
                    if (!buf_full && bus.mdu_valid && mdu_keep) begin
                        buf_full <= 1'b1;
                        buf_addr <= bus.mdu_addr;
                        buf_data <= bus.mdu_data;
                        wait_cnt <= 4'd0;
                        state    <= StHeld;
                    end
                end
            endcase
        end
    end

    assign bus.mdu_ready  = !buf_full;
    assign bus.stall_pipe = stall_pipe;
    assign bus.regwrite   = regwrite;
    assign bus.write_addr = write_addr;
    assign bus.write_data = write_data;
endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Bench for rf_wb_arbiter: directed scenarios, then random traffic against a transaction model.
module tb_rf_wb_arbiter;
    localparam int SM = 4;
`ifdef RF_ARB_ZERO_FILTER_EN
    localparam bit ZeroFilter = 1'b1;
`else
    localparam bit ZeroFilter = 1'b0;
`endif

    bit   clk = 1'b0;
    logic rst_n;
    int   checks = 0;
    int   errors = 0;

    logic [31:0] rf [32] = '{default: 32'd0};

    rf_wb_arbiter_if #(.addr_size(5), .word(32)) bus ();

    rf_wb_arbiter #(.addr_size(5), .word(32), .STARVE_MAX(SM)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Register file model: writes on the negedge after the outputs update.
    always @(negedge clk) begin
        if (bus.regwrite === 1'b1) rf[bus.write_addr] <= bus.write_data;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic set_pipe(input logic v, input logic [4:0] a, input logic [31:0] d);
        bus.pipe_valid = v;
        bus.pipe_addr  = a;
        bus.pipe_data  = d;
    endtask

    task automatic set_mdu(input logic v, input logic [4:0] a, input logic [31:0] d);
        bus.mdu_valid = v;
        bus.mdu_addr  = a;
        bus.mdu_data  = d;
    endtask

    function automatic logic writes(input logic [4:0] a);
        return !ZeroFilter || (a != 5'd0);
    endfunction

    initial begin
        // Random-phase model: one pending MDU result and the expected registered outputs.
        logic        pend_v, ready_now, stall_exp, prev_stall;
        logic [4:0]  pend_a, exp_a;
        logic [31:0] pend_d, exp_d;
        logic        exp_we;
        int          pend_t;

        rst_n = 1'b0;
        set_pipe(1'b0, 5'd0, 32'd0);
        set_mdu(1'b0, 5'd0, 32'd0);

        // Reset and idle.
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        chk("reset_regwrite", 32'(bus.regwrite), 32'd0);
        chk("reset_addr", 32'(bus.write_addr), 32'd0);
        chk("reset_data", bus.write_data, 32'd0);
        chk("reset_stall", 32'(bus.stall_pipe), 32'd0);
        chk("reset_ready", 32'(bus.mdu_ready), 32'd1);

        // Pipe-only write.
        set_pipe(1'b1, 5'd5, 32'hDEADBEEF);
        tick();
        set_pipe(1'b0, 5'd0, 32'd0);
        chk("pipe_regwrite", 32'(bus.regwrite), 32'd1);
        chk("pipe_addr", 32'(bus.write_addr), 32'd5);
        chk("pipe_data", bus.write_data, 32'hDEADBEEF);
        @(negedge clk);
        #1;
        chk("pipe_rf5", rf[5], 32'hDEADBEEF);

        // MDU result into an idle slot.
        tick();
        set_mdu(1'b1, 5'd9, 32'h1234);
        tick();
        set_mdu(1'b0, 5'd0, 32'd0);
        chk("mdu_ready_busy", 32'(bus.mdu_ready), 32'd0);
        chk("mdu_no_early_write", 32'(bus.regwrite), 32'd0);
        tick();
        chk("mdu_regwrite", 32'(bus.regwrite), 32'd1);
        chk("mdu_addr", 32'(bus.write_addr), 32'd9);
        chk("mdu_data", bus.write_data, 32'h1234);
        chk("mdu_ready_again", 32'(bus.mdu_ready), 32'd1);

        // Starvation: pipe writes every cycle while an MDU result waits.
        set_mdu(1'b1, 5'd3, 32'h3333);
        set_pipe(1'b1, 5'd10, 32'h110);
        tick();
        set_mdu(1'b0, 5'd0, 32'd0);
        chk("starve_w10", 32'(bus.write_addr), 32'd10);
        chk("starve_stall0", 32'(bus.stall_pipe), 32'd0);
        for (int a = 11; a <= 10 + SM; a++) begin
            set_pipe(1'b1, 5'(a), 32'h100 + 32'(a));
            tick();
            chk("starve_pipe_we", 32'(bus.regwrite), 32'd1);
            chk("starve_pipe_addr", 32'(bus.write_addr), 32'(a));
            chk("starve_stall", 32'(bus.stall_pipe), 32'(a == 10 + SM));
        end
        set_pipe(1'b1, 5'(11 + SM), 32'h100 + 32'(11 + SM));
        tick();
        chk("force_stall_off", 32'(bus.stall_pipe), 32'd0);
        chk("force_addr", 32'(bus.write_addr), 32'd3);
        chk("force_data", bus.write_data, 32'h3333);
        tick();
        set_pipe(1'b0, 5'd0, 32'd0);
        chk("held_pipe_we", 32'(bus.regwrite), 32'd1);
        chk("held_pipe_addr", 32'(bus.write_addr), 32'(11 + SM));
        chk("held_pipe_data", bus.write_data, 32'h100 + 32'(11 + SM));

        // Collision: younger pipe write to the buffered address wins.
        tick();
        set_mdu(1'b1, 5'd7, 32'hAAAA);
        tick();
        set_mdu(1'b0, 5'd0, 32'd0);
        set_pipe(1'b1, 5'd7, 32'hBBBB);
        chk("coll_idle", 32'(bus.regwrite), 32'd0);
        tick();
        set_pipe(1'b0, 5'd0, 32'd0);
        chk("coll_data", bus.write_data, 32'hBBBB);
        chk("coll_ready", 32'(bus.mdu_ready), 32'd1);
        tick();
        chk("coll_no_mdu_write", 32'(bus.regwrite), 32'd0);
        chk("coll_rf7", rf[7], 32'hBBBB);

        // Address 0.
        set_pipe(1'b1, 5'd0, 32'hFFFF);
        tick();
        set_pipe(1'b0, 5'd0, 32'd0);
        chk("zero_regwrite", 32'(bus.regwrite), 32'(!ZeroFilter));
        @(negedge clk);
        #1;
        chk("zero_rf0", rf[0], ZeroFilter ? 32'd0 : 32'hFFFF);

        // Reset while a result is buffered discards it.
        tick();
        set_mdu(1'b1, 5'd4, 32'h44);
        tick();
        set_mdu(1'b0, 5'd0, 32'd0);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        chk("rst_mid_ready", 32'(bus.mdu_ready), 32'd1);
        chk("rst_mid_addr", 32'(bus.write_addr), 32'd0);

        // Random traffic vs. transaction model, starting from reset state.
        pend_v = 1'b0; pend_a = '0; pend_d = '0; pend_t = 0;
        exp_we = 1'b0; exp_a = '0; exp_d = '0; prev_stall = 1'b0;
        for (int t = 0; t < 3000; t++) begin
            stall_exp = pend_v && (t == pend_t + 1 + SM);
            ready_now = !pend_v;
            chk("rnd_regwrite", 32'(bus.regwrite), 32'(exp_we));
            chk("rnd_addr", 32'(bus.write_addr), 32'(exp_a));
            chk("rnd_data", bus.write_data, exp_d);
            chk("rnd_stall", 32'(bus.stall_pipe), 32'(stall_exp));
            chk("rnd_ready", 32'(bus.mdu_ready), 32'(ready_now));

            // The pipeline re-presents the request it held through a stall.
            if (!prev_stall)
                set_pipe(($urandom % 4) != 0, 5'($urandom_range(0, 7)), $urandom);
            set_mdu(($urandom % 3) == 0, 5'($urandom_range(0, 7)), $urandom);

            exp_we = 1'b0;
            if (stall_exp) begin
                exp_we = 1'b1; exp_a = pend_a; exp_d = pend_d; pend_v = 1'b0;
            end else if (bus.pipe_valid) begin
                exp_we = writes(bus.pipe_addr); exp_a = bus.pipe_addr; exp_d = bus.pipe_data;
                if (pend_v && pend_a == bus.pipe_addr) pend_v = 1'b0;
            end else if (pend_v) begin
                exp_we = 1'b1; exp_a = pend_a; exp_d = pend_d; pend_v = 1'b0;
            end
            if (bus.mdu_valid && ready_now && writes(bus.mdu_addr)) begin
                pend_v = 1'b1; pend_a = bus.mdu_addr; pend_d = bus.mdu_data; pend_t = t;
            end
            prev_stall = stall_exp;
            tick();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/rf_wb_arbiter.md
# rf_wb_arbiter

Write-port arbiter and sequencer for the 32-entry register file. Shares the file's single write port between the in-order pipeline writeback stage and the multi-cycle multiply/divide unit (MDU). Buffers one MDU result, drains it into idle writeback slots, and forces a one-cycle pipeline stall when the MDU result has waited too long. Outputs are registered and drive the register file's `regwrite`/`write_addr`/`write_data` inputs directly; the file samples them on the following negedge.

## Interface
- `addr_size`, default 5: register address width.
- `word`, default 32: data width.
- `STARVE_MAX`, default 4: cycles a buffered MDU result may wait before a forced slot; legal range 1–15.

Ports:
- `clk`  in  1  clock; all state updates on posedge.
- `rst_n`  in  1  reset, synchronous, active-low.
- `pipe_valid`  in  1  pipeline writeback request this cycle; cannot be back-pressured except via `stall_pipe`.
- `pipe_addr`  in  addr_size  pipeline destination register.
- `pipe_data`  in  word  pipeline write data.
- `mdu_valid`  in  1  MDU result offered.
- `mdu_ready`  out  1  arbiter accepts the MDU result this cycle.
- `mdu_addr`  in  addr_size  MDU destination register.
- `mdu_data`  in  word  MDU result.
- `stall_pipe`  out  1  pipeline must hold its writeback request unchanged this cycle.
- `regwrite`  out  1  register file write enable (registered).
- `write_addr`  out  addr_size  register file write address (registered).
- `write_data`  out  word  register file write data (registered).

## Operation
- One-entry buffer: `buf_full`, `buf_addr`, `buf_data`. `mdu_ready = !buf_full`.
- MDU transfer happens when `mdu_valid && mdu_ready`; the entry is captured at posedge.
- State machine:
  - IDLE: buffer empty.
  - HELD: buffer full, waiting.
  - FORCE: starvation slot.
- Per-cycle grant priority at posedge:
  1. FORCE: write the buffer entry and ignore `pipe_valid`. Buffer empties; next state is IDLE.
  2. `pipe_valid`: write the pipe entry.
  3. Buffer full and `!pipe_valid`: write the buffer entry. Buffer empties.
  4. Otherwise: `regwrite` <= 0; `write_addr`/`write_data` hold their values.
- Address collision: when `pipe_valid`, buffer full, not FORCE, and `pipe_addr == buf_addr`, the pipe entry is written and the buffer entry is discarded (the younger write wins). The buffer empties and the state returns to IDLE.
- Wait counter (4 bits):
  - Clears when the buffer empties or fills.
  - Increments each cycle the buffer stays full and is not drained.
  - When the count reaches `STARVE_MAX`, next state is FORCE.
- `stall_pipe` is 1 exactly in FORCE state and is registered.
- An MDU capture cannot occur in the same cycle as a drain, because `mdu_ready` was 0. Maximum MDU throughput is one result per 2 cycles.

## Timing
- Reset values while `rst_n` = 0 at posedge:
  - `regwrite` = 0, `write_addr` = 0, `write_data` = 0.
  - `stall_pipe` = 0, buffer empty, counter 0, state IDLE.
  - `mdu_ready` = 1 from the first cycle after reset.
- Reset mid-operation discards any buffered MDU result with no write.
- Latency:
  - Pipe request at cycle N appears on `regwrite` in cycle N+1.
  - MDU accepted at N is written no earlier than N+2.
  - MDU accepted at N is written no later than N+2+`STARVE_MAX`.
- FORCE lasts exactly one cycle. The pipeline request held during FORCE is granted in the cycle after FORCE, because the buffer is empty and `pipe_valid` is still high.
- The register file writes on negedge, half a cycle after the outputs update. No combinational path exists from inputs to `regwrite`/`write_*`.

## Configuration
- `RF_ARB_ZERO_FILTER_EN` defined:
  - Any request with address 0 is granted but produces `regwrite` = 0 (MIPS `$zero` stays 0).
  - A buffered entry addressed to 0 is dropped on capture; `buf_full` stays 0.
- `RF_ARB_ZERO_FILTER_EN` undefined: address 0 is written like any other address.

## Test plan
- Reset/idle: hold `rst_n`=0 for 2 cycles, then release with no requests. Required: `regwrite`=0, `write_addr`=0, `write_data`=0, `stall_pipe`=0, `mdu_ready`=1.
- Pipe only:
  - Stimulus: `pipe_valid`=1, addr 5, data 0xDEADBEEF at cycle N.
  - Required: `regwrite`=1, `write_addr`=5, `write_data`=0xDEADBEEF in N+1; reading r5 after the negedge returns 0xDEADBEEF.
- MDU into idle slot:
  - Stimulus: MDU addr 9, data 0x1234 at N; pipe idle.
  - Required: `mdu_ready`=0 in N+1; write of r9=0x1234 in N+2; `mdu_ready`=1 in N+2.
- Starvation, with `STARVE_MAX`=4:
  - Stimulus: MDU addr 3 accepted; pipe writes addrs 10,11,12,… every cycle.
  - Required: `stall_pipe`=1 for one cycle, during which r3 is written; the held pipe write follows the next cycle; no pipe write is lost.
- Collision:
  - Stimulus: MDU addr 7, data 0xAAAA buffered; next cycle pipe writes addr 7, data 0xBBBB.
  - Required: a single write of r7=0xBBBB; 0xAAAA is never written; `mdu_ready`=1 the following cycle.
- Zero filter, with `RF_ARB_ZERO_FILTER_EN` defined:
  - Stimulus: pipe addr 0, data 0xFFFF.
  - Required: `regwrite` stays 0 and r0 reads 0. Without the macro, r0 reads 0xFFFF.
